mcp3208_scan: RTL and testbench

Round-robin scan sequencer that sits directly above the MCP3208 receiver. It issues `trigger`/`chan_in` to the receiver, paces conversions, and harvests the receiver's tagged result word. The receiver presents a conversion's result only at its next trigger, so this block pipelines captures one conversion behind and flushes on stop. Results land in an 8×12 register bank with per-channel valid flags, plus a one-cycle sample strobe for downstream consumers.

---
 rtl/mcp3208_scan.sv | 229 ++++++++++++++++++++++
 tb/tb_mcp3208_scan.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp3208_scan.sv
// Round-robin scan sequencer above the MCP3208 receiver: paces triggers, harvests the
// tagged result one conversion late, and keeps an 8x12 result bank with valid flags.
module mcp3208_scan #(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic [15:0] period,
    output logic        trigger,
    output logic [2:0]  chan_out,
    input  logic        adc_cs,
    input  logic [15:0] odata,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data,
    output logic [7:0]  valid,
    output logic        smp_valid,
    output logic [2:0]  smp_chan,
    output logic [11:0] smp_data,
    output logic        scan_done,
    output logic        err_tag,
    output logic        err_timeout
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 2);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StTrig      = 3'd1;
    localparam logic [2:0] StWaitStart = 3'd2;
    localparam logic [2:0] StWaitDone  = 3'd3;
    localparam logic [2:0] StGap       = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [2:0]      cur_q, cur_d, prev_q, prev_d;
    logic            pending_q, pending_d, flushing_q, flushing_d;
    logic [15:0]     gap_q, gap_d;
    logic [TmoW-1:0] tmo_q, tmo_d, tmo_inc;
    logic            trigger_q, trigger_d;
    logic [2:0]      chan_out_q, chan_out_d;
    logic [7:0]      valid_q, valid_d;
    logic            err_tag_q, err_tag_d, err_timeout_q, err_timeout_d;
    logic            smp_valid_q, smp_valid_d, scan_done_q, scan_done_d;
    logic [2:0]      smp_chan_q, smp_chan_d;
    logic [11:0]     smp_data_q, smp_data_d;
    logic [11:0]     bank_q [8];
    logic [11:0]     rd_data_q;
    logic            bank_we, tmo_trip, gap_met, run;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    function automatic logic [2:0] highest_bit(input logic [7:0] m);
        highest_bit = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) highest_bit = 3'(i);
        end
    endfunction

    // Search the doubled mask above c so the wrap to the lowest bit falls out naturally.
    function automatic logic [2:0] next_bit(input logic [7:0] m, input logic [2:0] c);
        logic [15:0] dbl;
        logic [3:0]  idx;
        dbl      = {m, m};
        next_bit = c;
        for (int k = 8; k >= 1; k--) begin
            idx = {1'b0, c} + 4'(k);
            if (dbl[idx]) next_bit = idx[2:0];
        end
    endfunction

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        prev_d        = prev_q;
        pending_d     = pending_q;
        flushing_d    = flushing_q;
        gap_d         = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;
        tmo_inc       = tmo_q + TmoW'(1);
        tmo_d         = '0;
        trigger_d     = 1'b0;
        chan_out_d    = chan_out_q;
        valid_d       = valid_q;
        err_tag_d     = err_tag_q;
        err_timeout_d = err_timeout_q;
        smp_valid_d   = 1'b0;
        smp_chan_d    = smp_chan_q;
        smp_data_d    = smp_data_q;
        scan_done_d   = 1'b0;
        bank_we       = 1'b0;
        tmo_trip      = (tmo_inc == TmoW'(TIMEOUT));
        gap_met       = ({1'b0, gap_q} + 17'd1) >= {1'b0, period};
        run           = enable & (|chan_mask);

        case (state_q)
            StIdle: begin
                if (run && adc_cs) begin
                    valid_d       = '0;
                    err_tag_d     = 1'b0;
                    err_timeout_d = 1'b0;
                    cur_d         = lowest_bit(chan_mask);
                    pending_d     = 1'b0;
                    flushing_d    = 1'b0;
                    trigger_d     = 1'b1;
                    chan_out_d    = lowest_bit(chan_mask);
                    state_d       = StTrig;
                end
            end
            StTrig: begin
                gap_d   = 16'd1;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                tmo_d = tmo_inc;
                // tmo_q is zero only in the first cycle, when odata holds the prior result.
                if (pending_q && (tmo_q == '0)) begin
                    if (!odata[15] && (odata[14:12] == prev_q)) begin
                        bank_we         = 1'b1;
                        valid_d[prev_q] = 1'b1;
                        smp_valid_d     = 1'b1;
                        smp_chan_d      = prev_q;
                        smp_data_d      = odata[11:0];
                        scan_done_d     = (prev_q == highest_bit(chan_mask));
                    end else begin
                        err_tag_d = 1'b1;
                    end
                end
                if (!adc_cs) begin
                    tmo_d   = '0;
                    state_d = StWaitDone;
                end else if (tmo_trip) begin
                    err_timeout_d = 1'b1;
                    pending_d     = 1'b0;
                    flushing_d    = 1'b0;
                    state_d       = StIdle;
                end
            end
            StWaitDone: begin
                tmo_d = tmo_inc;
                if (adc_cs) begin
                    tmo_d = '0;
                    if (flushing_q) begin
                        flushing_d = 1'b0;
                        pending_d  = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        prev_d    = cur_q;
                        pending_d = 1'b1;
                        cur_d     = next_bit(chan_mask, cur_q);
                        state_d   = StGap;
                    end
                end else if (tmo_trip) begin
                    err_timeout_d = 1'b1;
                    pending_d     = 1'b0;
                    flushing_d    = 1'b0;
                    state_d       = StIdle;
                end
            end
            StGap: begin
                if (gap_met) begin
                    // Without run this trigger only exists to pull out prev's result.
                    if (!run) flushing_d = 1'b1;
                    trigger_d  = 1'b1;
                    chan_out_d = cur_q;
                    state_d    = StTrig;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cur_q         <= '0;
            prev_q        <= '0;
            pending_q     <= 1'b0;
            flushing_q    <= 1'b0;
            gap_q         <= '0;
            tmo_q         <= '0;
            trigger_q     <= 1'b0;
            chan_out_q    <= '0;
            valid_q       <= '0;
            err_tag_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            smp_valid_q   <= 1'b0;
            smp_chan_q    <= '0;
            smp_data_q    <= '0;
            scan_done_q   <= 1'b0;
            rd_data_q     <= '0;
            for (int i = 0; i < 8; i++) bank_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            prev_q        <= prev_d;
            pending_q     <= pending_d;
            flushing_q    <= flushing_d;
            gap_q         <= gap_d;
            tmo_q         <= tmo_d;
            trigger_q     <= trigger_d;
            chan_out_q    <= chan_out_d;
            valid_q       <= valid_d;
            err_tag_q     <= err_tag_d;
            err_timeout_q <= err_timeout_d;
            smp_valid_q   <= smp_valid_d;
            smp_chan_q    <= smp_chan_d;
            smp_data_q    <= smp_data_d;
            scan_done_q   <= scan_done_d;
            rd_data_q     <= bank_q[rd_addr];
            if (bank_we) bank_q[prev_q] <= odata[11:0];
        end
    end

    assign trigger     = trigger_q;
    assign chan_out    = chan_out_q;
    assign rd_data     = rd_data_q;
    assign valid       = valid_q;
    assign smp_valid   = smp_valid_q;
    assign smp_chan    = smp_chan_q;
    assign smp_data    = smp_data_q;
    assign scan_done   = scan_done_q;
    assign err_tag     = err_tag_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mcp3208_scan.sv
// Bench for mcp3208_scan: a behavioural receiver answers triggers, and each scan is judged
// against the channel order implied by the mask and the results the receiver handed out.
`timescale 1ns/1ps
module tb_mcp3208_scan;

    localparam int unsigned Tmo = 15;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  chan_mask = '0;
    logic [15:0] period = '0;
    logic        trigger;
    logic [2:0]  chan_out;
    logic        adc_cs = 1'b1;
    logic [15:0] odata = '0;
    logic [2:0]  rd_addr = '0;
    logic [11:0] rd_data;
    logic [7:0]  valid;
    logic        smp_valid;
    logic [2:0]  smp_chan;
    logic [11:0] smp_data;
    logic        scan_done;
    logic        err_tag;
    logic        err_timeout;

    mcp3208_scan #(.TIMEOUT(Tmo)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .enable     (enable),
        .chan_mask  (chan_mask),
        .period     (period),
        .trigger    (trigger),
        .chan_out   (chan_out),
        .adc_cs     (adc_cs),
        .odata      (odata),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .valid      (valid),
        .smp_valid  (smp_valid),
        .smp_chan   (smp_chan),
        .smp_data   (smp_data),
        .scan_done  (scan_done),
        .err_tag    (err_tag),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Receiver model
    logic        hang = 1'b0;
    logic        fixed_codes = 1'b0;
    int          corrupt_idx = -1;
    int          len_min = 3;
    int          len_max = 12;
    logic [11:0] code_tbl [8];
    logic [15:0] rx_last = '0;
    int          rx_cnt = 0;
    int          rx_len;
    logic [11:0] rx_code;
    logic        rx_bad;
    logic [2:0]  rx_tag;
    logic [11:0] g_code[$];
    logic        g_bad[$];
    int          g_len[$];
    int          g_n = 0;

    initial begin
        forever begin
            @(posedge clock);
            if (trigger && !hang) begin
                rx_len  = int'($urandom_range(len_max, len_min));
                rx_code = fixed_codes ? code_tbl[chan_out] : 12'($urandom);
                rx_bad  = (g_n == corrupt_idx);
                rx_tag  = !rx_bad ? chan_out : ((chan_out == 3'd5) ? 3'd6 : 3'd5);
                odata   <= rx_last;
                rx_last = {1'b0, rx_tag, rx_code};
                rx_cnt  = rx_len + 1;
                g_code.push_back(rx_code);
                g_bad.push_back(rx_bad);
                g_len.push_back(rx_len);
                g_n++;
            end else if (rx_cnt > 0) begin
                adc_cs <= (rx_cnt == 1);
                rx_cnt--;
            end
        end
    end

    // Monitor
    int          cyc = 0;
    logic        cs_prev = 1'b1;
    int          t_cyc[$];
    logic [2:0]  t_chan[$];
    logic [2:0]  s_chan[$];
    logic [11:0] s_data[$];
    logic        s_done[$];
    int          done_cnt = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (rst_n) begin
            if (trigger) begin
                t_cyc.push_back(cyc);
                t_chan.push_back(chan_out);
                check_eq("trig_only_when_idle", 64'(cs_prev), 64'd1);
            end
            if (smp_valid) begin
                s_chan.push_back(smp_chan);
                s_data.push_back(smp_data);
                s_done.push_back(scan_done);
            end
            if (scan_done) done_cnt++;
        end
        cs_prev = adc_cs;
    end

    logic [11:0] bank_m [8];

    function automatic int nxt_ch(input logic [7:0] m, input int c);
        int k;
        k = c;
        for (int i = 0; i < 8; i++) begin
            k = (k + 1) % 8;
            if (m[k]) return k;
        end
        return c;
    endfunction

    function automatic int top_ch(input logic [7:0] m);
        for (int i = 7; i >= 0; i--) if (m[i]) return i;
        return 0;
    endfunction

    task automatic read_all();
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            @(negedge clock);
            check_eq($sformatf("rd_data[%0d]", a), 64'(rd_data), 64'(bank_m[a]));
        end
    endtask

    task automatic clear_logs();
        g_code.delete(); g_bad.delete(); g_len.delete(); g_n = 0;
        t_cyc.delete(); t_chan.delete();
        s_chan.delete(); s_data.delete(); s_done.delete();
        done_cnt = 0;
    endtask

    // Runs n conversions, drops enable during the n-th, and judges the whole scan.
    task automatic run_scan(input logic [7:0] m, input logic [15:0] p, input int n,
                            input int bad, input logic exact);
        int         seq[$];
        int         e_chan[$];
        logic [11:0] e_code[$];
        int         ch, budget, sp, lb, n_done;
        logic [7:0] vexp;
        logic       terr;
        clear_logs();
        corrupt_idx = bad;
        chan_mask = m;
        period = p;
        enable = 1'b1;
        budget = 0;
        while (t_chan.size() < n && budget < 20000) begin
            @(negedge clock);
            budget++;
        end
        enable = 1'b0;
        check_eq("scan_reached_n", 64'(t_chan.size() >= n), 64'd1);
        budget = 0;
        while (t_chan.size() < n + 1 && budget < 2000) begin
            @(negedge clock);
            budget++;
        end
        repeat (40) @(negedge clock);
        check_eq("trig_count", 64'(t_chan.size()), 64'(n + 1));

        ch = nxt_ch(m, 7);
        for (int i = 0; i <= n; i++) begin
            seq.push_back(ch);
            ch = nxt_ch(m, ch);
        end
        for (int i = 0; i < t_chan.size() && i <= n; i++) begin
            check_eq("trig_chan", 64'(t_chan[i]), 64'(seq[i]));
            if (i > 0 && i - 1 < g_len.size()) begin
                sp = t_cyc[i] - t_cyc[i-1];
                lb = (int'(p) > g_len[i-1] + 2) ? int'(p) : g_len[i-1] + 2;
                check_eq("trig_spacing_min", 64'(sp >= lb), 64'd1);
                if (exact) check_eq("trig_spacing", 64'(sp), 64'(p));
            end
        end

        vexp = '0;
        terr = 1'b0;
        n_done = 0;
        for (int i = 0; i < n && i < g_code.size(); i++) begin
            if (g_bad[i]) begin
                terr = 1'b1;
            end else begin
                e_chan.push_back(seq[i]);
                e_code.push_back(g_code[i]);
                vexp[seq[i]] = 1'b1;
                bank_m[seq[i]] = g_code[i];
                if (seq[i] == top_ch(m)) n_done++;
            end
        end
        check_eq("smp_count", 64'(s_chan.size()), 64'(e_chan.size()));
        for (int k = 0; k < s_chan.size() && k < e_chan.size(); k++) begin
            check_eq("smp_chan", 64'(s_chan[k]), 64'(e_chan[k]));
            check_eq("smp_data", 64'(s_data[k]), 64'(e_code[k]));
            check_eq("scan_done_at_top", 64'(s_done[k]), 64'(e_chan[k] == top_ch(m)));
        end
        check_eq("scan_done_count", 64'(done_cnt), 64'(n_done));
        check_eq("valid", 64'(valid), 64'(vexp));
        check_eq("err_tag", 64'(err_tag), 64'(terr));
        check_eq("err_timeout", 64'(err_timeout), 64'd0);
        read_all();
    endtask

    initial begin
        int budget, t0, n, bad;
        logic [7:0] m;
        for (int a = 0; a < 8; a++) begin
            bank_m[a] = '0;
            code_tbl[a] = 12'($urandom);
        end
        repeat (3) @(negedge clock);
        check_eq("reset_outputs",
                 {trigger, chan_out, rd_data, valid, smp_valid, smp_chan, smp_data,
                  scan_done, err_tag, err_timeout}, 64'd0);
        rst_n = 1'b1;
        @(negedge clock);
        read_all();

        // Two-channel scan with fixed codes, then the same with a corrupted ch2 tag.
        code_tbl[0] = 12'h123;
        code_tbl[2] = 12'hABC;
        fixed_codes = 1'b1;
        run_scan(8'h05, 16'd0, 6, -1, 1'b0);
        rd_addr = 3'd2;
        @(negedge clock);
        check_eq("rd_ch2", 64'(rd_data), 64'h0ABC);
        rd_addr = 3'd0;
        @(negedge clock);
        check_eq("rd_ch0", 64'(rd_data), 64'h0123);
        run_scan(8'h05, 16'd0, 6, 3, 1'b0);
        fixed_codes = 1'b0;

        // Receiver ignores the trigger: expect a sticky timeout and a return to idle.
        clear_logs();
        hang = 1'b1;
        chan_mask = 8'h40;
        period = '0;
        enable = 1'b1;
        budget = 0;
        while (t_chan.size() < 1 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        enable = 1'b0;
        check_eq("timeout_trig_seen", 64'(t_chan.size()), 64'd1);
        t0 = (t_cyc.size() > 0) ? t_cyc[0] : cyc;
        budget = 0;
        while (!err_timeout && budget < 40) begin
            @(negedge clock);
            budget++;
        end
        check_eq("timeout_latency_max", 64'((cyc - t0) <= 16), 64'd1);
        check_eq("timeout_latency_min", 64'((cyc - t0) >= 15), 64'd1);
        repeat (10) @(negedge clock);
        check_eq("timeout_sticky", 64'(err_timeout), 64'd1);
        check_eq("timeout_no_retrigger", 64'(t_chan.size()), 64'd1);
        hang = 1'b0;

        repeat (6) begin
            m = 8'($urandom_range(255, 1));
            n = int'($urandom_range(8, 1));
            bad = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n - 1, 0)) : -1;
            run_scan(m, 16'($urandom_range(30, 0)), n, bad, 1'b0);
        end

        // Fixed pacing, then a reset while the receiver is mid-conversion.
        len_min = 12;
        len_max = 12;
        run_scan(8'h08, 16'd200, 3, -1, 1'b1);
        t_chan.delete();
        t_cyc.delete();
        enable = 1'b1;
        budget = 0;
        while (t_chan.size() < 1 && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        repeat (4) @(negedge clock);
        check_eq("busy_before_rst", 64'(adc_cs), 64'd0);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_outputs_async",
                    {trigger, chan_out, rd_data, valid, smp_valid, smp_chan, smp_data,
                     scan_done, err_tag, err_timeout}, 64'd0);
        for (int a = 0; a < 8; a++) bank_m[a] = '0;
        @(negedge clock);
        rst_n = 1'b1;
        check_eq("busy_after_rst", 64'(adc_cs), 64'd0);
        run_scan(8'h08, 16'd200, 2, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
